// File: rtl/sw_boundary_buffer.sv
// rtl/sw_boundary_buffer.sv - boundary feed for the first PE of a Smith-Waterman systolic array
//
// Pass 0 streams fresh target bases with zero V/F scores. Every later pass
// replays, through an internal circular FIFO, the tuples the last PE emitted
// during the previous pass. Pass and position counting is internal.
//
// Optional build macro: SW_BUF_BYPASS_EN
//   defined   - in FEED_BUF, a push arriving while the FIFO is empty is forwarded
//               straight to out_* and is not stored (no underflow bubble)
//   undefined - that push is stored and becomes poppable the following cycle
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   start                           one-cycle pulse, begins an alignment (ignored while busy)
//   in_valid, in_t, in_ready        fresh-base stream (accepted in FEED_IN only)
//   last_valid, last_t/v/f          last-PE outputs, pushed into the replay FIFO
//   out_valid, out_t/v/f            registered feed to the first PE
//   busy                            state is not IDLE
//   done                            one-cycle pulse once the alignment is fully fed
//   overflow                        sticky, a push was dropped on a full FIFO
//   occupancy                       FIFO entries held
module sw_boundary_buffer #(
  parameter int T_W     = 2,
  parameter int SCORE_W = 12,
  parameter int REF_LEN = 128,
  parameter int N_PASS  = 4,
  parameter int DEPTH   = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [T_W-1:0]             in_t,
  output logic                       in_ready,
  input  logic                       last_valid,
  input  logic [T_W-1:0]             last_t,
  input  logic [SCORE_W-1:0]         last_v,
  input  logic [SCORE_W-1:0]         last_f,
  output logic                       out_valid,
  output logic [T_W-1:0]             out_t,
  output logic [SCORE_W-1:0]         out_v,
  output logic [SCORE_W-1:0]         out_f,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W    = $clog2(DEPTH + 1);
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int POS_W    = $clog2(REF_LEN + 1);
  localparam int PASS_W   = $clog2(N_PASS + 1);
  localparam int WR_LIMIT = (N_PASS - 1) * REF_LEN;
  localparam int WR_W     = $clog2(WR_LIMIT + 2);
  localparam int E_W      = T_W + 2 * SCORE_W;

  localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(REF_LEN - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(N_PASS - 1);
  localparam logic [WR_W-1:0]   WR_MAX    = WR_W'(WR_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED_IN,
    S_FEED_BUF,
    S_FINISH
  } state_t;

  state_t             state, state_nxt;
  logic [POS_W-1:0]   pos_cnt, pos_nxt;
  logic [PASS_W-1:0]  pass_cnt, pass_nxt;
  logic [WR_W-1:0]    wr_cnt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [E_W-1:0]     mem [DEPTH];
  logic [E_W-1:0]     push_data, rd_data, out_q, out_data_nxt;
  logic               out_valid_nxt, done_nxt, start_ok;
  logic               push_req, push_ok, push_drop, push_store, pop, bypass;

  assign push_data = {last_t, last_v, last_f};
  assign rd_data   = mem[rd_ptr];
  assign {out_t, out_v, out_f} = out_q;
  assign in_ready  = (state == S_FEED_IN);
  assign busy      = (state != S_IDLE);
  assign start_ok  = (state == S_IDLE) && start;

  // Only the first (N_PASS-1) passes are fed back; the final pass output is
  // discarded. wr_cnt counts stored (or forwarded) pushes, so a push dropped
  // on a full FIFO does not consume a slot of the replay window.
  assign push_req  = (state != S_IDLE) && last_valid && (wr_cnt < WR_MAX);
  assign push_drop = push_req && (occupancy == OCC_FULL);
  assign push_ok   = push_req && (occupancy != OCC_FULL);

  // Emptiness is judged on the registered occupancy, so a push into an empty
  // FIFO can never be popped in the same cycle.
  assign pop = (state == S_FEED_BUF) && (occupancy != '0);

`ifdef SW_BUF_BYPASS_EN
  assign bypass = (state == S_FEED_BUF) && (occupancy == '0) && push_ok;
`else
  assign bypass = 1'b0;
`endif

  assign push_store = push_ok && !bypass;

  always_comb begin
    state_nxt     = state;
    pos_nxt       = pos_cnt;
    pass_nxt      = pass_cnt;
    out_valid_nxt = 1'b0;
    out_data_nxt  = '0;
    done_nxt      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FEED_IN;
          pos_nxt   = '0;
          pass_nxt  = '0;
        end
      end
      S_FEED_IN: begin
        if (in_valid) begin
          out_valid_nxt = 1'b1;
          out_data_nxt  = {in_t, {SCORE_W{1'b0}}, {SCORE_W{1'b0}}};
          pos_nxt       = pos_cnt + POS_W'(1);
          if (pos_cnt == POS_LAST) begin
            pos_nxt   = '0;
            pass_nxt  = PASS_W'(1);
            state_nxt = (N_PASS > 1) ? S_FEED_BUF : S_FINISH;
          end
        end
      end
      S_FEED_BUF: begin
        if (pop || bypass) begin
          out_valid_nxt = 1'b1;
          out_data_nxt  = pop ? rd_data : push_data;
          pos_nxt       = pos_cnt + POS_W'(1);
          if (pos_cnt == POS_LAST) begin
            pos_nxt  = '0;
            pass_nxt = pass_cnt + PASS_W'(1);
            if (pass_cnt == PASS_LAST) begin
              state_nxt = S_FINISH;
            end
          end
        end
      end
      S_FINISH: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pos_cnt   <= '0;
      pass_cnt  <= '0;
      wr_cnt    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pos_cnt   <= pos_nxt;
      pass_cnt  <= pass_nxt;
      out_valid <= out_valid_nxt;
      out_q     <= out_data_nxt;
      done      <= done_nxt;
      // start is only honoured in IDLE, where no push can be in flight
      if (start_ok) begin
        wr_cnt   <= '0;
        overflow <= 1'b0;
      end else begin
        if (push_ok) wr_cnt <= wr_cnt + WR_W'(1);
        if (push_drop) overflow <= 1'b1;
      end
      if (push_store) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      occupancy <= occupancy + OCC_W'(push_store) - OCC_W'(pop);
    end
  end

  // Storage is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push_store) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_sw_boundary_buffer.sv
// tb/tb_sw_boundary_buffer.sv - randomized self-checking bench for sw_boundary_buffer
module tb_sw_boundary_buffer;
  localparam int RL     = 4;
  localparam int NP     = 3;
  localparam int DP     = 4;
  localparam int NOUT   = NP * RL;
  localparam int NSTORE = (NP - 1) * RL;
`ifdef SW_BUF_BYPASS_EN
  localparam int EXP_GAP = 2;
`else
  localparam int EXP_GAP = 3;
`endif

  typedef struct packed {
    logic [1:0]  t;
    logic [11:0] v;
    logic [11:0] f;
  } tup_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid, in_ready, last_valid, out_valid, busy, done, overflow;
  logic [1:0]  in_t, last_t, out_t;
  logic [11:0] last_v, last_f, out_v, out_f;
  logic [2:0]  occupancy;
  logic        d_start, d_in_valid, d_in_ready, d_last_valid, d_out_valid, d_busy, d_done, d_overflow;
  logic [1:0]  d_in_t, d_last_t, d_out_t;
  logic [11:0] d_last_v, d_last_f, d_out_v, d_out_f;
  logic [2:0]  d_occupancy;

  int   checks, errors;
  logic [1:0] base_t [RL];
  tup_t pd [64];
  tup_t exp_q[$], got_q[$];
  int   got_cyc[$];
  int   done_cyc, done_cnt, max_occ, ovf_seen, inrdy5;

  always #5 clk = ~clk;

  sw_boundary_buffer #(.T_W(2), .SCORE_W(12), .REF_LEN(RL), .N_PASS(NP), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_t(in_t), .in_ready(in_ready),
    .last_valid(last_valid), .last_t(last_t), .last_v(last_v), .last_f(last_f),
    .out_valid(out_valid), .out_t(out_t), .out_v(out_v), .out_f(out_f),
    .busy(busy), .done(done), .overflow(overflow), .occupancy(occupancy));

  sw_boundary_buffer #(.T_W(2), .SCORE_W(12), .REF_LEN(RL), .N_PASS(1), .DEPTH(DP)) dut_deg (
    .clk(clk), .rst(rst), .start(d_start), .in_valid(d_in_valid), .in_t(d_in_t), .in_ready(d_in_ready),
    .last_valid(d_last_valid), .last_t(d_last_t), .last_v(d_last_v), .last_f(d_last_f),
    .out_valid(d_out_valid), .out_t(d_out_t), .out_v(d_out_v), .out_f(d_out_f),
    .busy(d_busy), .done(d_done), .overflow(d_overflow), .occupancy(d_occupancy));

  // Emulates an upstream base source and a last PE that echoes one tuple per
  // first-PE output after a delay. Expected stream: pass 0 bases with zero
  // scores, then the first NSTORE pushed tuples in order.
  task automatic run_align(input int in_prob, input int dly_min, input int dly_max,
                           input int stall_from, input int stall_len);
    int bi, np;
    int sched[$];
    bi = 0; np = 0;
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    done_cyc = -1; done_cnt = 0; max_occ = 0; ovf_seen = 0; inrdy5 = -1;
    for (int i = 0; i < RL; i++) exp_q.push_back({base_t[i], 12'd0, 12'd0});
    for (int i = 0; i < NSTORE; i++) exp_q.push_back(pd[i]);
    for (int n = 0; n < 400; n++) begin
      start    = (n == 0);
      in_valid = (bi < RL) && ($urandom_range(99) < in_prob);
      in_t     = (bi < RL) ? base_t[bi] : 2'd0;
      last_valid = 1'b0;
      if (sched.size() > 0 && sched[0] <= n && !(n >= stall_from && n < stall_from + stall_len)) begin
        last_valid = 1'b1;
        {last_t, last_v, last_f} = pd[np];
      end
      @(negedge clk);
      if (in_valid && in_ready) bi++;
      if (last_valid) begin np++; void'(sched.pop_front()); end
      if (out_valid && got_q.size() < 60) begin
        got_q.push_back({out_t, out_v, out_f});
        got_cyc.push_back(n);
        sched.push_back(n + int'($urandom_range(dly_max, dly_min)));
      end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = n; end
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (overflow) ovf_seen = 1;
      if (n == 5) inrdy5 = int'(in_ready);
      @(posedge clk); #1;
      if (done_cyc >= 0 && n >= done_cyc + 3) break;
    end
    start = 1'b0; in_valid = 1'b0; last_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if ({out_valid, out_t, out_v, out_f, done, overflow, in_ready, busy, occupancy} !== '0) begin
      errors++; $display("FAIL reset_outputs got %b exp all zero",
        {out_valid, out_t, out_v, out_f, done, overflow, in_ready, busy, occupancy}); end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n <= 5; n++) begin
      start = (n == 0); in_valid = (n <= 4); in_t = 2'(n);
      last_valid = (n == 2 || n == 3); last_t = 2'd1; last_v = 12'(n); last_f = 12'(n);
      if (n < 5) begin @(posedge clk); #1; end
    end
    start = 1'b0; in_valid = 1'b0; last_valid = 1'b0;
    #2;
    checks++; if ({busy, out_valid, occupancy} !== {1'b1, 1'b1, 3'd2}) begin
      errors++; $display("FAIL pre_reset_state got busy=%b ov=%b occ=%0d exp 1 1 2", busy, out_valid, occupancy); end
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, busy, occupancy, done} !== '0) begin
      errors++; $display("FAIL async_reset got ov=%b busy=%b occ=%0d done=%b exp 0", out_valid, busy, occupancy, done); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle got done=%b busy=%b exp 0 0", done, busy); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_pass0_replay();
    tup_t fixed [4];
    fixed[0] = {2'd1, 12'd5, 12'd7};
    fixed[1] = {2'd2, 12'd9, 12'd3};
    fixed[2] = {2'd0, 12'd4, 12'd4};
    fixed[3] = {2'd3, 12'd12, 12'd0};
    for (int i = 0; i < RL; i++) base_t[i] = 2'(i);
    for (int i = 0; i < 64; i++) begin
      pd[i].t = 2'($urandom); pd[i].v = 12'($urandom); pd[i].f = 12'($urandom);
    end
    for (int i = 0; i < 4; i++) pd[i] = fixed[i];
    run_align(100, 2, 2, 0, 0);
    checks++; if (got_q.size() != NOUT) begin
      errors++; $display("FAIL replay_count got %0d exp %0d", got_q.size(), NOUT); end
    for (int i = 0; i < NOUT && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL replay_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() == NOUT) begin
      checks++; if (got_cyc[0] != 2 || got_cyc[NOUT-1] != 13) begin
        errors++; $display("FAIL replay_timing got first=%0d last=%0d exp 2 13", got_cyc[0], got_cyc[NOUT-1]); end
    end
    checks++; if (inrdy5 != 0) begin
      errors++; $display("FAIL feed_buf_in_ready got %0d exp 0", inrdy5); end
    checks++; if (done_cnt != 1 || done_cyc != 14) begin
      errors++; $display("FAIL replay_done got cnt=%0d cyc=%0d exp 1 14", done_cnt, done_cyc); end
    checks++; if (occupancy !== 3'd0 || ovf_seen != 0) begin
      errors++; $display("FAIL replay_leftover got occ=%0d ovf=%0d exp 0 0", occupancy, ovf_seen); end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < RL; i++) base_t[i] = 2'(3 - i);
    for (int i = 0; i < 64; i++) begin
      pd[i].t = 2'($urandom); pd[i].v = 12'($urandom); pd[i].f = 12'($urandom);
    end
    run_align(100, 2, 2, 4, 3);
    checks++; if (got_q.size() != NOUT) begin
      errors++; $display("FAIL underflow_count got %0d exp %0d", got_q.size(), NOUT); end
    for (int i = 0; i < NOUT && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL underflow_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > RL) begin
      checks++; if (got_cyc[RL] - got_cyc[RL-1] - 1 != EXP_GAP) begin
        errors++; $display("FAIL underflow_bubbles got %0d exp %0d", got_cyc[RL] - got_cyc[RL-1] - 1, EXP_GAP); end
    end
    checks++; if (done_cnt != 1) begin
      errors++; $display("FAIL underflow_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_overflow();
    tup_t ov [10];
    tup_t got[$];
    int pushed, bi, dc;
    for (int i = 0; i < 10; i++) begin
      ov[i].t = 2'($urandom); ov[i].v = 12'($urandom); ov[i].f = 12'($urandom);
    end
    pushed = 0; bi = 0; dc = -1;
    for (int n = 0; n < 200; n++) begin
      start = (n == 0);
      last_valid = 1'b0;
      if (n == 0) begin last_valid = 1'b1; {last_t, last_v, last_f} = ov[9]; end
      else if (n <= 5) begin last_valid = 1'b1; {last_t, last_v, last_f} = ov[n-1]; end
      else if (n >= 14 && pushed < 4) begin last_valid = 1'b1; {last_t, last_v, last_f} = ov[5+pushed]; end
      in_valid = (n >= 6) && (bi < RL);
      in_t = 2'(bi);
      @(negedge clk);
      if (n == 5) begin
        checks++; if (occupancy !== 3'd4 || overflow !== 1'b0) begin
          errors++; $display("FAIL fill_to_full got occ=%0d ovf=%b exp 4 0", occupancy, overflow); end
      end
      if (n == 6) begin
        checks++; if (occupancy !== 3'd4 || overflow !== 1'b1) begin
          errors++; $display("FAIL overflow_set got occ=%0d ovf=%b exp 4 1", occupancy, overflow); end
      end
      if (in_valid && in_ready) bi++;
      if (n >= 14 && last_valid) pushed++;
      if (out_valid && got.size() < 60) got.push_back({out_t, out_v, out_f});
      if (done && dc < 0) dc = n;
      @(posedge clk); #1;
      if (dc >= 0) break;
    end
    start = 1'b0; in_valid = 1'b0; last_valid = 1'b0;
    checks++; if (got.size() != NOUT) begin
      errors++; $display("FAIL overflow_count got %0d exp %0d", got.size(), NOUT); end
    for (int i = 0; i < NOUT && i < got.size(); i++) begin
      tup_t e;
      if (i < RL) e = {2'(i), 12'd0, 12'd0};
      else if (i < 2 * RL) e = ov[i-RL];
      else e = ov[i-2*RL+5];
      checks++; if (got[i] !== e) begin
        errors++; $display("FAIL overflow_data[%0d] got %h exp %h", i, got[i], e); end
    end
    checks++; if (overflow !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL overflow_sticky got ovf=%b busy=%b exp 1 0", overflow, busy); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (overflow !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL overflow_clear got ovf=%b busy=%b exp 0 1", overflow, busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int dmin;
      for (int i = 0; i < RL; i++) base_t[i] = 2'($urandom);
      for (int i = 0; i < 64; i++) begin
        pd[i].t = 2'($urandom); pd[i].v = 12'($urandom); pd[i].f = 12'($urandom);
      end
      dmin = int'($urandom_range(3, 1));
      run_align(int'($urandom_range(100, 30)), dmin, dmin + int'($urandom_range(3)),
                int'($urandom_range(15)), int'($urandom_range(4)));
      checks++; if (got_q.size() != NOUT) begin
        errors++; $display("FAIL rand%0d_count got %0d exp %0d", r, got_q.size(), NOUT); end
      for (int i = 0; i < NOUT && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_data[%0d] got %h exp %h", r, i, got_q[i], exp_q[i]); end
      end
      checks++; if (done_cnt != 1 || got_q.size() == 0 || done_cyc != got_cyc[got_cyc.size()-1] + 1) begin
        errors++; $display("FAIL rand%0d_done got cnt=%0d cyc=%0d exp 1 pulse one cycle after last output", r, done_cnt, done_cyc); end
      checks++; if (occupancy !== 3'd0 || ovf_seen != 0 || max_occ > DP) begin
        errors++; $display("FAIL rand%0d_fifo got occ=%0d ovf=%0d max=%0d exp 0 0 <=%0d", r, occupancy, ovf_seen, max_occ, DP); end
    end
  endtask

  task automatic test_degenerate();
    logic [1:0] b [RL];
    tup_t got[$];
    int gc[$];
    int dc, dcnt, maxo;
    for (int i = 0; i < RL; i++) b[i] = 2'($urandom);
    dc = -1; dcnt = 0; maxo = 0;
    for (int n = 0; n < 12; n++) begin
      d_start = (n == 0);
      d_in_valid = (n >= 1 && n <= RL);
      d_in_t = (n >= 1 && n <= RL) ? b[n-1] : 2'd0;
      d_last_valid = 1'b1;
      d_last_t = 2'($urandom); d_last_v = 12'($urandom); d_last_f = 12'($urandom);
      @(negedge clk);
      if (d_out_valid) begin got.push_back({d_out_t, d_out_v, d_out_f}); gc.push_back(n); end
      if (d_done) begin dcnt++; if (dc < 0) dc = n; end
      if (int'(d_occupancy) > maxo) maxo = int'(d_occupancy);
      @(posedge clk); #1;
    end
    d_start = 1'b0; d_in_valid = 1'b0; d_last_valid = 1'b0;
    checks++; if (got.size() != RL) begin
      errors++; $display("FAIL degen_count got %0d exp %0d", got.size(), RL); end
    for (int i = 0; i < RL && i < got.size(); i++) begin
      checks++; if (got[i] !== {b[i], 12'd0, 12'd0}) begin
        errors++; $display("FAIL degen_data[%0d] got %h exp %h", i, got[i], {b[i], 12'd0, 12'd0}); end
    end
    checks++; if (dcnt != 1 || got.size() != RL || dc != gc[RL-1] + 1) begin
      errors++; $display("FAIL degen_done got cnt=%0d cyc=%0d exp 1 at 6", dcnt, dc); end
    checks++; if (maxo != 0 || d_busy !== 1'b0) begin
      errors++; $display("FAIL degen_fifo got max_occ=%0d busy=%b exp 0 0", maxo, d_busy); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    start = 1'b0; in_valid = 1'b0; in_t = '0;
    last_valid = 1'b0; last_t = '0; last_v = '0; last_f = '0;
    d_start = 1'b0; d_in_valid = 1'b0; d_in_t = '0;
    d_last_valid = 1'b0; d_last_t = '0; d_last_v = '0; d_last_f = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_pass0_replay();
    test_underflow();
    test_overflow();
    test_random();
    test_degenerate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
